// File: rtl/debounce_multi.sv
// Multi-channel input debouncer: optional synchronizer, per-channel
// stability counter, registered level plus rise/fall pulses.
module debounce_multi #(
    parameter int   N_CH        = 4,
    parameter int   STABLE_CNT  = 3,
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] sig_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] busy
);

    localparam int CLG = $clog2(STABLE_CNT + 1);
    localparam int CW  = (CLG < 1) ? 1 : CLG;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [N_CH-1:0] s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [N_CH-1:0] chain [SYNC_STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++)
                        chain[k] <= {N_CH{RST_VAL}};
                end else begin
                    chain[0] <= sig_in;
                    for (int k = 1; k < SYNC_STAGES; k++)
                        chain[k] <= chain[k-1];
                end
            end

            assign s = chain[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = sig_in;
        end
    endgenerate

    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic [N_CH-1:0] out_d;
    logic [N_CH-1:0] rise_d;
    logic [N_CH-1:0] fall_d;

    // Any sample matching the current level drops all accumulated credit.
    always_comb begin
        out_d  = sig_out;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != sig_out[i]) begin
                if (cnt_q[i] == CMAX) begin
                    out_d[i]  = s[i];
                    rise_d[i] = s[i];
                    fall_d[i] = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_out <= {N_CH{RST_VAL}};
            rise    <= '0;
            fall    <= '0;
            for (int i = 0; i < N_CH; i++)
                cnt_q[i] <= '0;
        end else begin
            sig_out <= out_d;
            rise    <= rise_d;
            fall    <= fall_d;
            for (int i = 0; i < N_CH; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < N_CH; i++)
            busy[i] = (cnt_q[i] != '0);
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Random and directed stimulus for two debounce_multi builds, checked
// against a sample-history model of the debounce rule.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sig_in = 4'b0000;

    logic [3:0] out_a, rise_a, fall_a, busy_a;
    logic [3:0] out_b, rise_b, fall_b, busy_b;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(4), .STABLE_CNT(3), .SYNC_STAGES(2), .RST_VAL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .sig_out(out_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
    );

    debounce_multi #(
        .N_CH(4), .STABLE_CNT(1), .SYNC_STAGES(0), .RST_VAL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .sig_in(sig_in),
        .sig_out(out_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    endtask

    // h[k] = sig_in seen at the k-th most recent rising edge (0 = latest)
    logic [3:0] h [8];
    logic [3:0] m_out [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    logic [3:0] m_busy [2];

    task automatic model_reset();
        for (int k = 0; k < 8; k++) h[k] = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            m_out[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_busy[c] = 0;
        end
    endtask

    // Output flips once the last n samples all disagree with it;
    // busy means the newest sample still disagrees.
    task automatic model_cfg(input int c, input int sync, input int n);
        logic [3:0] old;
        logic       flip;
        old = m_out[c];
        for (int ch = 0; ch < 4; ch++) begin
            flip = 1'b1;
            for (int j = 0; j < n; j++)
                if (h[sync+j][ch] == old[ch]) flip = 1'b0;
            if (flip) m_out[c][ch] = ~old[ch];
        end
        m_rise[c] = m_out[c] & ~old;
        m_fall[c] = ~m_out[c] & old;
        m_busy[c] = h[sync] ^ m_out[c];
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".out_a"},  out_a,  m_out[0]);
        check({tag, ".rise_a"}, rise_a, m_rise[0]);
        check({tag, ".fall_a"}, fall_a, m_fall[0]);
        check({tag, ".busy_a"}, busy_a, m_busy[0]);
        check({tag, ".out_b"},  out_b,  m_out[1]);
        check({tag, ".rise_b"}, rise_b, m_rise[1]);
        check({tag, ".fall_b"}, fall_b, m_fall[1]);
        check({tag, ".busy_b"}, busy_b, m_busy[1]);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        for (int k = 7; k > 0; k--) h[k] = h[k-1];
        h[0] = sig_in;
        model_cfg(0, 2, 3);
        model_cfg(1, 0, 1);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic pulse_rst(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        compare_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #3;
        compare_all("rst_hold");
        #20;
        @(posedge clk); #1;
        compare_all("rst_edges");
        rst = 1'b0;

        // single channel rises after five edges
        sig_in = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            step("t1");
            if (e == 1) check("t1.b_out_e1", out_b, 4'b0001);
            if (e == 3 || e == 4) check("t1.busy0", busy_a, 4'b0001);
            if (e == 4) check("t1.out_e4", out_a, 4'b0000);
            if (e == 5) begin
                check("t1.out_e5", out_a, 4'b0001);
                check("t1.rise_e5", rise_a, 4'b0001);
            end
            if (e == 6) check("t1.rise_e6", rise_a, 4'b0000);
        end

        // short dropout is rejected
        sig_in = 4'b0000;
        step("t2"); step("t2");
        sig_in = 4'b0001;
        for (int e = 0; e < 6; e++) step("t2");
        check("t2.out", out_a, 4'b0001);
        check("t2.busy", busy_a, 4'b0000);

        pulse_rst("t3_rst");
        sig_in = 4'b1010;
        for (int e = 1; e <= 6; e++) begin
            step("t3");
            if (e == 5) check("t3.rise", rise_a, 4'b1010);
        end

        pulse_rst("t4_rst0");
        sig_in = 4'b0100;
        step("t4"); step("t4"); step("t4");
        pulse_rst("t4_rst");
        for (int e = 1; e <= 5; e++) step("t4b");
        check("t4.out", out_a, 4'b0100);

        pulse_rst("t5_rst");
        for (int e = 0; e < 20; e++) begin
            sig_in = {2'b00, e[0], 1'b0};
            step("t5");
        end
        check("t5.out1", out_a & 4'b0010, 4'b0000);

        pulse_rst("t6_rst");
        sig_in = 4'b1000;
        step("t6");
        check("t6.b_out", out_b, 4'b1000);
        check("t6.b_rise", rise_b, 4'b1000);
        step("t6");
        check("t6.b_rise2", rise_b, 4'b0000);

        // random slow-toggling inputs with occasional resets
        for (int e = 0; e < 600; e++) begin
            logic [3:0] fl;
            for (int b = 0; b < 4; b++) fl[b] = ($urandom_range(0, 3) == 0);
            sig_in = sig_in ^ fl;
            if ($urandom_range(0, 99) == 0) pulse_rst("rnd_rst");
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
